booth_opnd_stage: RTL and testbench
===================================

Name: booth_opnd_stage

Overview:
- Registered operand-capture stage directly upstream of the Booth-4/Wallace 16x16 multiplier core.
- Accepts a signed multiplicand/multiplier pair over a valid/ready handshake.
- Pre-computes the two's-complement negation of the multiplicand with an invert-plus-one ripple chain of XOR/OR cells.
- Presents A, -A and B from registers, so the partial-product selector does not sit behind the negation ripple.

Parameters:
WIDTH, 16, operand width in bits (signed two's complement); must be >= 2

Ports:
sys_clk    input   1        rising-edge clock
sys_rst_n  input   1        asynchronous active-low reset
in_valid   input   1        upstream operand pair valid
in_ready   output  1        stage can accept; registered
in_a       input   WIDTH    multiplicand, signed
in_b       input   WIDTH    multiplier, signed
out_valid  output  1        registered operand set valid to core
out_ready  input   1        core accepts operand set
out_a      output  WIDTH+1  multiplicand sign-extended by one bit
out_nega   output  WIDTH+1  -(sign-extended multiplicand), exact
out_b      output  WIDTH    multiplier, passed through

Behaviour:
- Reset (sys_rst_n=0, async):
  - out_valid=0, in_ready=1.
  - All data registers (main and skid) = 0.
  - An in-flight operand set is discarded; no output appears after reset release until a new in_valid&in_ready transfer.
- Transfers:
  - Input transfer when in_valid&in_ready at a rising edge.
  - Output transfer when out_valid&out_ready at a rising edge.
- Negation, computed combinationally on the input side before the registers:
  - ea = sign-extend(in_a) to WIDTH+1.
  - neg[0] = ea[0]; or[0] = ea[0].
  - For i>=1: neg[i] = ea[i] XOR or[i-1]; or[i] = ea[i] OR or[i-1].
  - No adder is permitted.
  - Result is exact in WIDTH+1 bits: in_a = -2^(WIDTH-1) gives +2^(WIDTH-1) (no overflow); in_a = 0 gives 0.
- Storage: main register (drives outputs) plus one skid register, each holding {ea, neg, in_b}.
- State machine:
  - EMPTY: out_valid=0, in_ready=1. Input transfer -> ONE (data to main).
  - ONE: out_valid=1, in_ready=1.
    - Input and output together -> ONE (new data to main).
    - Output only -> EMPTY.
    - Input only (out_ready=0) -> TWO (new data to skid).
    - Neither -> ONE, hold.
  - TWO: out_valid=1, in_ready=0.
    - Output transfer -> ONE (skid moves to main).
    - Otherwise hold.
- Latency: accepted input visible on outputs the next cycle when the stage was EMPTY or draining. Throughput is 1 set/cycle with out_ready held high.
- Ordering is strictly FIFO; no set is dropped or duplicated.
- Stability: while out_valid=1 and out_ready=0, out_a/out_nega/out_b hold unchanged.
- in_ready depends only on state; there is no combinational path from out_ready to in_ready.
- Inputs are ignored while in_ready=0.
- out_a/out_nega/out_b are don't-care while out_valid=0, but must not be X after reset.

Test Plan:
- Reset:
  - Assert sys_rst_n=0 mid-stream while in TWO -> out_valid=0, in_ready=1 immediately (async).
  - After release, no stale set is emitted.
- Single transfer:
  - in_a=16'h0003, in_b=16'h0005, out_ready=1 -> one cycle later out_valid=1, out_a=17'h00003, out_nega=17'h1FFFD, out_b=16'h0005.
- Negation boundaries:
  - in_a=16'h8000 -> out_a=17'h18000, out_nega=17'h08000.
  - in_a=16'h0000 -> out_nega=17'h00000.
  - in_a=16'hFFFF -> out_nega=17'h00001.
  - in_a=16'h7FFF -> out_nega=17'h18001.
- Backpressure:
  - out_ready=0; send sets S1, S2 -> in_ready falls to 0 after S2 is accepted; outputs hold S1.
  - Raise out_ready -> S1 then S2 on consecutive cycles, then EMPTY.
- Streaming: 1000 random sets with random in_valid/out_ready toggling -> scoreboard matches order and out_nega == -sext(in_a) for every set.
- Simultaneous events: in state ONE with in_valid=1 and out_ready=1 every cycle for 20 cycles -> one set out per cycle, in_ready stays 1, no entry to TWO.

Source files
------------

// File: rtl/booth_opnd_stage.sv
// Operand-capture stage ahead of the Booth-4/Wallace multiplier core.
// Registers A (sign-extended), -A and B behind a two-entry valid/ready
// buffer (main + skid) so the core never sees the negation ripple.
module booth_opnd_stage #(
    parameter int WIDTH = 16
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   out_a,
    output logic [WIDTH:0]   out_nega,
    output logic [WIDTH-1:0] out_b
);

    // One stored set is {ea, neg, b}
    localparam int DW = 3 * WIDTH + 2;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t          r_state;
    logic            r_in_ready;
    logic            r_out_valid;
    logic [DW-1:0]   r_main;
    logic [DW-1:0]   r_skid;

    logic [WIDTH:0]  w_ea;
    logic [WIDTH:0]  w_neg;
    logic [WIDTH:0]  w_or;
    logic [DW-1:0]   w_in_data;
    logic            w_in_xfer;
    logic            w_out_xfer;
    logic            w_load_main_in;
    logic            w_load_main_skid;
    logic            w_load_skid;

    // Invert-plus-one negation as an XOR/OR ripple: bits up to and including
    // the lowest set bit pass through, every bit above it is inverted.
    always_comb begin
        w_ea     = {in_a[WIDTH-1], in_a};
        w_neg    = '0;
        w_or     = '0;
        w_neg[0] = w_ea[0];
        w_or[0]  = w_ea[0];
        for (int unsigned i = 1; i <= WIDTH; i++) begin
            w_neg[i] = w_ea[i] ^ w_or[i-1];
            w_or[i]  = w_ea[i] | w_or[i-1];
        end
        w_in_data = {w_ea, w_neg, in_b};
    end

    // Handshake decode and register load enables
    always_comb begin
        w_in_xfer        = in_valid & r_in_ready;
        w_out_xfer       = r_out_valid & out_ready;
        w_load_main_in   = w_in_xfer & ((r_state == EMPTY) | w_out_xfer);
        w_load_skid      = w_in_xfer & (r_state == ONE) & ~w_out_xfer;
        w_load_main_skid = (r_state == TWO) & w_out_xfer;
    end

    // Occupancy FSM with registered in_ready/out_valid
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state     <= EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_in_xfer) begin
                        r_state     <= ONE;
                        r_out_valid <= 1'b1;
                        r_in_ready  <= 1'b1;
                    end
                end
                ONE: begin
                    if (w_out_xfer && !w_in_xfer) begin
                        r_state     <= EMPTY;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end else if (w_in_xfer && !w_out_xfer) begin
                        r_state     <= TWO;
                        r_out_valid <= 1'b1;
                        r_in_ready  <= 1'b0;
                    end
                end
                TWO: begin
                    if (w_out_xfer) begin
                        r_state     <= ONE;
                        r_out_valid <= 1'b1;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= EMPTY;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

    // Main and skid data registers; skid only fills when the core stalls
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_main <= '0;
            r_skid <= '0;
        end else begin
            if (w_load_main_in) begin
                r_main <= w_in_data;
            end else if (w_load_main_skid) begin
                r_main <= r_skid;
            end
            if (w_load_skid) begin
                r_skid <= w_in_data;
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_a     = r_main[DW-1 -: WIDTH+1];
    assign out_nega  = r_main[WIDTH +: WIDTH+1];
    assign out_b     = r_main[WIDTH-1:0];

endmodule

// File: tb/tb_booth_opnd_stage.sv
// Directed and randomised checks for booth_opnd_stage (WIDTH=16).
module tb_booth_opnd_stage;

    localparam int W = 16;

    logic          sys_clk;
    logic          sys_rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic          out_valid;
    logic          out_ready;
    logic [W:0]    out_a;
    logic [W:0]    out_nega;
    logic [W-1:0]  out_b;

    int checks = 0;
    int errors = 0;

    booth_opnd_stage #(.WIDTH(W)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_a     (out_a),
        .out_nega  (out_nega),
        .out_b     (out_b)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_a      = '0;
        in_b      = '0;
        #12;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        checks++;
        if ({out_a, out_nega, out_b} !== 50'd0) begin
            errors++; $display("FAIL reset_data: got %h/%h/%h want 0", out_a, out_nega, out_b);
        end
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_a      = 16'h0003;
        in_b      = 16'h0005;
        tick();
        in_valid  = 1'b0;
        checks++;
        if (out_valid !== 1'b1) begin
            errors++; $display("FAIL single_valid: got %b want 1", out_valid);
        end
        checks++;
        if (out_a !== 17'h00003 || out_nega !== 17'h1FFFD || out_b !== 16'h0005) begin
            errors++; $display("FAIL single_data: got %h/%h/%h want 00003/1fffd/0005",
                               out_a, out_nega, out_b);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL single_drain: got %b want 0", out_valid);
        end
    endtask

    task automatic test_negation();
        logic [W-1:0] va   [4];
        logic [W:0]   ea   [4];
        logic [W:0]   en   [4];
        va[0] = 16'h8000; ea[0] = 17'h18000; en[0] = 17'h08000;
        va[1] = 16'h0000; ea[1] = 17'h00000; en[1] = 17'h00000;
        va[2] = 16'hFFFF; ea[2] = 17'h1FFFF; en[2] = 17'h00001;
        va[3] = 16'h7FFF; ea[3] = 17'h07FFF; en[3] = 17'h18001;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_a     = va[k];
            in_b     = 16'(k + 16'h00A0);
            tick();
            in_valid = 1'b0;
            checks++;
            if (out_valid !== 1'b1 || out_a !== ea[k] || out_nega !== en[k]
                || out_b !== 16'(k + 16'h00A0)) begin
                errors++; $display("FAIL neg_boundary[%0d]: got v=%b a=%h n=%h b=%h want a=%h n=%h",
                                   k, out_valid, out_a, out_nega, out_b, ea[k], en[k]);
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_a = 16'h1111; in_b = 16'hAAAA;      // S1
        tick();
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_b !== 16'hAAAA) begin
            errors++; $display("FAIL bp_s1: got v=%b r=%b b=%h want 1/1/aaaa", out_valid, in_ready, out_b);
        end
        in_a = 16'h2222; in_b = 16'hBBBB;      // S2
        tick();
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            errors++; $display("FAIL bp_full: got r=%b v=%b want 0/1", in_ready, out_valid);
        end
        in_a = 16'h3333; in_b = 16'hCCCC;      // offered while full, must be ignored
        tick();
        checks++;
        if (out_a !== 17'h01111 || out_nega !== 17'h1EEEF || out_b !== 16'hAAAA || in_ready !== 1'b0) begin
            errors++; $display("FAIL bp_hold: got a=%h n=%h b=%h r=%b want 01111/1eeef/aaaa/0",
                               out_a, out_nega, out_b, in_ready);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_a !== 17'h02222 || out_nega !== 17'h1DDDE
            || out_b !== 16'hBBBB || in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_s2: got v=%b a=%h n=%h b=%h r=%b want 1/02222/1ddde/bbbb/1",
                               out_valid, out_a, out_nega, out_b, in_ready);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_empty: got v=%b r=%b want 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_back_to_back();
        logic [W:0] ea;
        out_ready = 1'b1;
        for (int k = 0; k < 21; k++) begin
            in_valid = 1'b1;
            in_a     = 16'(16'hFFF0 + k * 3);
            in_b     = 16'(k);
            ea       = {in_a[W-1], in_a};
            tick();
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_b !== 16'(k)
                || out_a !== ea || out_nega !== 17'(-ea)) begin
                errors++; $display("FAIL b2b[%0d]: got v=%b r=%b a=%h n=%h b=%h want 1/1/%h/%h/%h",
                                   k, out_valid, in_ready, out_a, out_nega, out_b, ea, 17'(-ea), 16'(k));
            end
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL b2b_drain: got %b want 0", out_valid);
        end
    endtask

    task automatic test_streaming();
        logic [3*W+1:0] q[$];
        logic [W:0]     ea;
        bit             stream_err;
        int             sent;
        int             budget;
        sent = 0;
        stream_err = 0;
        for (int cyc = 0; cyc < 4000 && sent < 1000; cyc++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_a      = 16'($urandom);
            in_b      = 16'($urandom);
            ea        = {in_a[W-1], in_a};
            checks++;
            if (out_valid !== (q.size() != 0) || in_ready !== (q.size() < 2)) begin
                errors++; $display("FAIL stream_ctrl[%0d]: got v=%b r=%b occupancy=%0d", cyc, out_valid, in_ready, q.size());
            end
            if (q.size() != 0) begin
                checks++;
                if ({out_a, out_nega, out_b} !== q[0]) begin
                    errors++; $display("FAIL stream_data[%0d]: got %h want %h", cyc, {out_a, out_nega, out_b}, q[0]);
                end
            end
            if (out_valid && out_ready && q.size() != 0) void'(q.pop_front());
            if (in_valid && in_ready) begin
                q.push_back({ea, 17'(-ea), in_b});
                sent++;
            end
            tick();
        end
        checks++;
        if (sent != 1000) begin
            errors++; $display("FAIL stream_count: got %0d sets sent want 1000", sent);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        budget    = 0;
        while (q.size() != 0 && budget < 10) begin
            checks++;
            if (out_valid !== 1'b1 || {out_a, out_nega, out_b} !== q[0]) begin
                errors++; $display("FAIL stream_drain: got v=%b %h want %h", out_valid, {out_a, out_nega, out_b}, q[0]);
            end
            void'(q.pop_front());
            tick();
            budget++;
        end
        checks++;
        if (out_valid !== 1'b0 || q.size() != 0) begin
            errors++; $display("FAIL stream_end: got v=%b left=%0d want 0/0", out_valid, q.size());
        end
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_a = 16'h4444; in_b = 16'h1234;
        tick();
        in_a = 16'h5555; in_b = 16'h5678;
        tick();
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            errors++; $display("FAIL rst_mid_pre: got r=%b v=%b want 0/1", in_ready, out_valid);
        end
        #2;
        sys_rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL rst_mid_async: got v=%b r=%b want 0/1", out_valid, in_ready);
        end
        @(negedge sys_clk);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                errors++; $display("FAIL rst_mid_stale[%0d]: got v=%b r=%b want 0/1", k, out_valid, in_ready);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_negation();
        test_backpressure();
        test_back_to_back();
        test_streaming();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
